// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared widths, timeout and FSM encoding for mem_arbiter
// Revision: 1.0
// ============================================================================
package mem_arbiter_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int TMO_W   = $clog2(TIMEOUT);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // A request is valid only when exactly one of read/write is asserted.
  function automatic logic valid_req(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : two requester ports plus the downstream memory bus
// Revision: 1.0
// ============================================================================
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              p0_read;
  logic              p0_write;
  logic [ADDR_W-1:0] p0_address;
  logic [DATA_W-1:0] p0_write_data;
  logic [DATA_W-1:0] p0_read_data;
  logic              p0_busy_wait;

  logic              p1_read;
  logic              p1_write;
  logic [ADDR_W-1:0] p1_address;
  logic [DATA_W-1:0] p1_write_data;
  logic [DATA_W-1:0] p1_read_data;
  logic              p1_busy_wait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_busy_wait;

  logic              err_illegal;

  modport slave (
    input  p0_read, p0_write, p0_address, p0_write_data,
    output p0_read_data, p0_busy_wait,
    input  p1_read, p1_write, p1_address, p1_write_data,
    output p1_read_data, p1_busy_wait,
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data, mem_busy_wait,
    output err_illegal
  );

  modport master (
    output p0_read, p0_write, p0_address, p0_write_data,
    input  p0_read_data, p0_busy_wait,
    output p1_read, p1_write, p1_address, p1_write_data,
    input  p1_read_data, p1_busy_wait,
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data, mem_busy_wait,
    input  err_illegal
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-requester round-robin grant, one-hot output
// Revision: 1.0
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    // On contention the port not served last wins.
    if (&req_i) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin arbiter sharing one data memory between two masters
// Revision: 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              illegal;
  logic              releasing;

  assign req[0]  = valid_req(bus.p0_read, bus.p0_write);
  assign req[1]  = valid_req(bus.p1_read, bus.p1_write);
  assign illegal = (bus.p0_read & bus.p0_write) | (bus.p1_read & bus.p1_write);

  rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    tmo_d        = tmo_q;
    err_d        = err_q | illegal;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d     = gnt[1] & ~gnt[0];
          mem_read_d  = gnt[1] ? bus.p1_read       : bus.p0_read;
          mem_write_d = gnt[1] ? bus.p1_write      : bus.p0_write;
          addr_d      = gnt[1] ? bus.p1_address    : bus.p0_address;
          wdata_d     = gnt[1] ? bus.p1_write_data : bus.p0_write_data;
          tmo_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_busy_wait) begin
          tmo_d   = '0;
          state_d = WAIT;
        end else if (tmo_q == TMO_LAST) begin
          // Memory never acknowledged: drop the command and release the port.
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          tmo_d       = '0;
          state_d     = RELEASE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT: begin
        if (!bus.mem_busy_wait) begin
          if (mem_read_q) begin
            if (grant_q) p1_rdata_d = bus.mem_read_data;
            else         p0_rdata_d = bus.mem_read_data;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy_wait drops for the single RELEASE cycle of the granted port.
  assign releasing        = (state_q == RELEASE);
  assign bus.p0_busy_wait = req[0] & ~(releasing & ~grant_q);
  assign bus.p1_busy_wait = req[1] & ~(releasing &  grant_q);

  assign bus.p0_read_data   = p0_rdata_q;
  assign bus.p1_read_data   = p1_rdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.err_illegal    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory: busy for mem_lat cycles after seeing a command.
  logic [7:0] mem [256];
  int         mem_lat = 2;
  bit         mem_en  = 1'b1;
  int         mem_cnt;
  bit         mem_done;

  always @(posedge clk) begin
    if (!rst) begin
      mem_cnt           <= 0;
      mem_done          <= 1'b0;
      bus.mem_busy_wait <= 1'b0;
      bus.mem_read_data <= 8'h00;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        bus.mem_busy_wait <= 1'b0;
        mem_done          <= 1'b1;
        if (bus.mem_read)  bus.mem_read_data <= mem[bus.mem_address];
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
      end
    end else if (!(bus.mem_read || bus.mem_write)) begin
      mem_done <= 1'b0;
    end else if (mem_en && !mem_done) begin
      bus.mem_busy_wait <= 1'b1;
      mem_cnt           <= mem_lat;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_free(input int port, input int limit, output int cycles);
    cycles = 0;
    while (((port == 0) ? bus.p0_busy_wait : bus.p1_busy_wait) && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_first(input int limit, output int cycles);
    cycles = 0;
    while (bus.p0_busy_wait && bus.p1_busy_wait && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    bus.p0_read = 0; bus.p0_write = 0; bus.p0_address = 0; bus.p0_write_data = 0;
    bus.p1_read = 0; bus.p1_write = 0; bus.p1_address = 0; bus.p1_write_data = 0;
    do_reset();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.err_illegal, bus.p0_busy_wait, bus.p1_busy_wait} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rd/wr/err/b0/b1=%b want 00000",
               {bus.mem_read, bus.mem_write, bus.err_illegal, bus.p0_busy_wait, bus.p1_busy_wait});
    end
    checks++;
    if ({bus.mem_address, bus.mem_write_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: got addr/wdata=%h want 0000", {bus.mem_address, bus.mem_write_data});
    end
    checks++;
    if ({bus.p0_read_data, bus.p1_read_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0000", {bus.p0_read_data, bus.p1_read_data});
    end
  endtask

  task automatic test_single_read();
    int cyc;
    mem[8'h04] <= 8'h11;
    mem_lat = 10;
    bus.p0_read = 1; bus.p0_address = 8'h04;
    #1;
    checks++;
    if (bus.p0_busy_wait !== 1'b1) begin
      errors++;
      $display("FAIL read_busy_hi: got %b want 1", bus.p0_busy_wait);
    end
    wait_free(0, 60, cyc);
    checks++;
    if (cyc !== 13) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles want 13", cyc);
    end
    checks++;
    if (bus.p0_read_data !== 8'h11) begin
      errors++;
      $display("FAIL read_data: got %h want 11", bus.p0_read_data);
    end
    checks++;
    if ({bus.p1_busy_wait, bus.p1_read_data, bus.mem_read} !== 10'h000) begin
      errors++;
      $display("FAIL read_p1_untouched: got b1/rd1/mrd=%h want 000",
               {bus.p1_busy_wait, bus.p1_read_data, bus.mem_read});
    end
    bus.p0_read = 0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int cyc;
    do_reset();
    mem_lat = 3;
    bus.p0_write = 1; bus.p0_address = 8'h05; bus.p0_write_data = 8'h2A;
    bus.p1_read  = 1; bus.p1_address = 8'h05;
    #1;
    wait_first(60, cyc);
    checks++;
    if ({bus.p0_busy_wait, bus.p1_busy_wait} !== 2'b01) begin
      errors++;
      $display("FAIL simul_order: got b0/b1=%b want 01", {bus.p0_busy_wait, bus.p1_busy_wait});
    end
    bus.p0_write = 0;
    wait_free(1, 60, cyc);
    checks++;
    if (bus.p1_read_data !== 8'h2A) begin
      errors++;
      $display("FAIL simul_p1_read: got %h want 2a", bus.p1_read_data);
    end
    bus.p1_read = 0;
    @(negedge clk);
    // Port 1 was served last, so port 0 must win the next tie.
    bus.p0_read = 1; bus.p0_address = 8'h05;
    bus.p1_read = 1; bus.p1_address = 8'h05;
    #1;
    wait_first(60, cyc);
    checks++;
    if ({bus.p0_busy_wait, bus.p1_busy_wait, bus.p0_read_data} !== {2'b01, 8'h2A}) begin
      errors++;
      $display("FAIL simul_rr_again: got b0/b1=%b rd0=%h want 01 2a",
               {bus.p0_busy_wait, bus.p1_busy_wait}, bus.p0_read_data);
    end
    bus.p0_read = 0;
    wait_free(1, 60, cyc);
    bus.p1_read = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    mem[8'h10] <= 8'hA5;
    mem[8'h11] <= 8'h5A;
    mem_lat = 2;
    bus.p1_read = 1; bus.p1_address = 8'h10;
    repeat (3) @(negedge clk);
    bus.p1_address = 8'h11;
    #1;
    wait_free(1, 60, cyc);
    checks++;
    if (bus.p1_read_data !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_latched_addr: got %h want a5", bus.p1_read_data);
    end
    @(negedge clk);
    checks++;
    if (bus.p1_busy_wait !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: got busy %b want 1 after one-cycle gap", bus.p1_busy_wait);
    end
    wait_free(1, 60, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles want 5", cyc);
    end
    checks++;
    if ({bus.p1_read_data, bus.p0_read_data, bus.p0_busy_wait} !== {8'h5A, 8'h2A, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: got rd1=%h rd0=%h b0=%b want 5a 2a 0",
               bus.p1_read_data, bus.p0_read_data, bus.p0_busy_wait);
    end
    bus.p1_read = 0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bit saw_cmd;
    do_reset();
    bus.p0_read = 1; bus.p0_write = 1; bus.p0_address = 8'h04;
    #1;
    checks++;
    if (bus.p0_busy_wait !== 1'b0) begin
      errors++;
      $display("FAIL illegal_busy: got %b want 0", bus.p0_busy_wait);
    end
    saw_cmd = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) saw_cmd = 1'b1;
    end
    checks++;
    if (saw_cmd !== 1'b0) begin
      errors++;
      $display("FAIL illegal_no_cmd: got command %b want 0", saw_cmd);
    end
    bus.p0_read = 0; bus.p0_write = 0;
    @(negedge clk);
    checks++;
    if (bus.err_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: got err %b want 1", bus.err_illegal);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    mem[8'h20] <= 8'h77;
    mem[8'h21] <= 8'h99;
    mem_lat = 2; mem_en = 1'b1;
    bus.p1_read = 1; bus.p1_address = 8'h20;
    #1;
    wait_free(1, 60, cyc);
    bus.p1_read = 0;
    @(negedge clk);
    checks++;
    if ({bus.err_illegal, bus.p1_read_data} !== {1'b0, 8'h77}) begin
      errors++;
      $display("FAIL tmo_pre: got err=%b rd1=%h want 0 77", bus.err_illegal, bus.p1_read_data);
    end
    mem_en = 1'b0;
    bus.p1_read = 1; bus.p1_address = 8'h21;
    #1;
    wait_free(1, 60, cyc);
    checks++;
    if (cyc !== 17) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles want 17", cyc);
    end
    checks++;
    if ({bus.mem_read, bus.err_illegal, bus.p1_read_data} !== {1'b0, 1'b1, 8'h77}) begin
      errors++;
      $display("FAIL tmo_release: got mrd=%b err=%b rd1=%h want 0 1 77",
               bus.mem_read, bus.err_illegal, bus.p1_read_data);
    end
    bus.p1_read = 0;
    mem_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int cyc;
    do_reset();
    mem[8'h06] <= 8'h00;
    mem_lat = 10;
    bus.p0_read = 1; bus.p0_address = 8'h04;
    #1;
    wait_free(0, 60, cyc);
    bus.p0_read = 0;
    @(negedge clk);
    checks++;
    if (bus.p0_read_data !== 8'h11) begin
      errors++;
      $display("FAIL rstw_pre: got rd0=%h want 11", bus.p0_read_data);
    end
    bus.p0_write = 1; bus.p0_address = 8'h06; bus.p0_write_data = 8'h33;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.mem_write, bus.mem_busy_wait} !== 2'b11) begin
      errors++;
      $display("FAIL rstw_inflight: got mwr/mbusy=%b want 11", {bus.mem_write, bus.mem_busy_wait});
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data,
         bus.p0_read_data, bus.err_illegal, bus.p0_busy_wait} !== {2'b00, 24'h000000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstw_values: got rd=%b wr=%b a=%h wd=%h rd0=%h err=%b b0=%b want 0 0 00 00 00 0 1",
               bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data,
               bus.p0_read_data, bus.err_illegal, bus.p0_busy_wait);
    end
    @(negedge clk);
    checks++;
    if ({bus.mem_write, bus.mem_address} !== {1'b1, 8'h06}) begin
      errors++;
      $display("FAIL rstw_restart: got mwr=%b addr=%h want 1 06", bus.mem_write, bus.mem_address);
    end
    wait_free(0, 60, cyc);
    checks++;
    if (mem[8'h06] !== 8'h33) begin
      errors++;
      $display("FAIL rstw_write: got mem[06]=%h want 33", mem[8'h06]);
    end
    bus.p0_write = 0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
